// File: rtl/fp_pkg.sv
// Shared definitions for the FP compare pipeline: op encodings, per-width field sizes,
// canonical NaNs and the operand class record.
package fp_pkg;

    localparam logic [2:0] FP_OP_FMIN = 3'd0;
    localparam logic [2:0] FP_OP_FMAX = 3'd1;
    localparam logic [2:0] FP_OP_FEQ  = 3'd2;
    localparam logic [2:0] FP_OP_FLT  = 3'd3;
    localparam logic [2:0] FP_OP_FLE  = 3'd4;

    localparam int unsigned EXP_W_32 = 8;
    localparam int unsigned MAN_W_32 = 23;
    localparam int unsigned EXP_W_64 = 11;
    localparam int unsigned MAN_W_64 = 52;

    localparam logic [31:0] CANON_NAN_32 = 32'h7FC0_0000;
    localparam logic [63:0] CANON_NAN_64 = 64'h7FF8_0000_0000_0000;

    typedef struct packed {
        logic is_nan;
        logic is_snan;
        logic is_zero;
        logic sign;
    } fp_class_t;

endpackage

// File: rtl/fp_compare_pipe_if.sv
// Request/response bundle of the FP compare unit: valid/ready in, valid/ready out.
interface fp_compare_pipe_if #(
    parameter int unsigned BUS_WIDTH = 64,
    parameter int unsigned TAG_WIDTH = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           in_op;
    logic [BUS_WIDTH-1:0] in_a;
    logic [BUS_WIDTH-1:0] in_b;
    logic [TAG_WIDTH-1:0] in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [BUS_WIDTH-1:0] out_result;
    logic                 out_nv;
    logic [TAG_WIDTH-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_nv, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_nv, out_tag
    );
endinterface

// File: rtl/fp_classify.sv
// Combinational operand classifier: NaN / signalling NaN / zero / sign for one operand.
module fp_classify
    import fp_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 64
) (
    input  logic [BUS_WIDTH-1:0] operand,
    output fp_class_t            cls
);
    localparam int unsigned EXP_W = (BUS_WIDTH == 32) ? EXP_W_32 : EXP_W_64;
    localparam int unsigned MAN_W = (BUS_WIDTH == 32) ? MAN_W_32 : MAN_W_64;

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;

    assign exp_f = operand[BUS_WIDTH-2 -: EXP_W];
    assign man_f = operand[MAN_W-1:0];

    always_comb begin
        cls.sign    = operand[BUS_WIDTH-1];
        cls.is_nan  = (&exp_f) & (|man_f);
        // Quiet bit is the mantissa MSB; clear means signalling.
        cls.is_snan = cls.is_nan & ~man_f[MAN_W-1];
        cls.is_zero = ~|operand[BUS_WIDTH-2:0];
    end
endmodule

// File: rtl/fp_compare_pipe.sv
// Two-stage FMIN/FMAX/FEQ/FLT/FLE unit with NV flag and tag passthrough.
// S1 registers operand classes and raw magnitude compares; S2 registers the selected result.
module fp_compare_pipe
    import fp_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 64,
    parameter int unsigned TAG_WIDTH = 5
) (
    input logic               clk,
    input logic               rst,
    fp_compare_pipe_if.slave  bus
);
    localparam logic [BUS_WIDTH-1:0] CANON_NAN =
        (BUS_WIDTH == 32) ? BUS_WIDTH'(CANON_NAN_32) : BUS_WIDTH'(CANON_NAN_64);

    logic adv1, adv2;
    fp_class_t cls_a, cls_b;

    logic                 s1_valid_q;
    logic [2:0]           s1_op_q;
    logic [TAG_WIDTH-1:0] s1_tag_q;
    fp_class_t            s1_cls_a_q, s1_cls_b_q;
    logic                 s1_mag_lt_q, s1_mag_eq_q;
    logic [BUS_WIDTH-1:0] s1_a_q, s1_b_q;

    logic                 out_valid_q;
    logic [BUS_WIDTH-1:0] out_result_q;
    logic                 out_nv_q;
    logic [TAG_WIDTH-1:0] out_tag_q;

    logic [BUS_WIDTH-1:0] result_d;
    logic                 nv_d;
    logic any_nan, any_snan, both_zero, bits_eq, a_lt, b_lt, num_lt, num_eq;

    fp_classify #(.BUS_WIDTH(BUS_WIDTH)) u_cls_a (.operand(bus.in_a), .cls(cls_a));
    fp_classify #(.BUS_WIDTH(BUS_WIDTH)) u_cls_b (.operand(bus.in_b), .cls(cls_b));

    assign adv2          = ~out_valid_q | bus.out_ready;
    assign adv1          = ~s1_valid_q | adv2;
    assign bus.in_ready  = adv1;
    assign bus.out_valid = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_nv    = out_nv_q;
    assign bus.out_tag   = out_tag_q;

    always_comb begin
        any_nan   = s1_cls_a_q.is_nan | s1_cls_b_q.is_nan;
        any_snan  = s1_cls_a_q.is_snan | s1_cls_b_q.is_snan;
        both_zero = s1_cls_a_q.is_zero & s1_cls_b_q.is_zero;
        bits_eq   = (s1_cls_a_q.sign == s1_cls_b_q.sign) & s1_mag_eq_q;
        // Total sign/magnitude order, so -0 sorts below +0.
        if (s1_cls_a_q.sign != s1_cls_b_q.sign) begin
            a_lt = s1_cls_a_q.sign;
        end else if (s1_cls_a_q.sign) begin
            a_lt = ~s1_mag_lt_q & ~s1_mag_eq_q;
        end else begin
            a_lt = s1_mag_lt_q;
        end
        b_lt   = ~a_lt & ~bits_eq;
        num_eq = bits_eq | both_zero;
        num_lt = a_lt & ~both_zero;

        result_d = '0;
        nv_d     = 1'b0;
        case (s1_op_q)
            FP_OP_FMIN, FP_OP_FMAX: begin
                nv_d = any_snan;
                if (s1_cls_a_q.is_nan & s1_cls_b_q.is_nan) begin
                    result_d = CANON_NAN;
                end else if (s1_cls_a_q.is_nan) begin
                    result_d = s1_b_q;
                end else if (s1_cls_b_q.is_nan) begin
                    result_d = s1_a_q;
                end else if (s1_op_q == FP_OP_FMIN) begin
                    result_d = b_lt ? s1_b_q : s1_a_q;
                end else begin
                    result_d = a_lt ? s1_b_q : s1_a_q;
                end
            end
            FP_OP_FEQ: begin
                nv_d        = any_snan;
                result_d[0] = ~any_nan & num_eq;
            end
            FP_OP_FLT: begin
                nv_d        = any_nan;
                result_d[0] = ~any_nan & num_lt;
            end
            FP_OP_FLE: begin
                nv_d        = any_nan;
                result_d[0] = ~any_nan & (num_lt | num_eq);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_op_q      <= '0;
            s1_tag_q     <= '0;
            s1_cls_a_q   <= '0;
            s1_cls_b_q   <= '0;
            s1_mag_lt_q  <= 1'b0;
            s1_mag_eq_q  <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_nv_q     <= 1'b0;
            out_tag_q    <= '0;
        end else begin
            if (adv1) begin
                s1_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_op_q     <= bus.in_op;
                    s1_tag_q    <= bus.in_tag;
                    s1_cls_a_q  <= cls_a;
                    s1_cls_b_q  <= cls_b;
                    s1_mag_lt_q <= bus.in_a[BUS_WIDTH-2:0] < bus.in_b[BUS_WIDTH-2:0];
                    s1_mag_eq_q <= bus.in_a[BUS_WIDTH-2:0] == bus.in_b[BUS_WIDTH-2:0];
                    s1_a_q      <= bus.in_a;
                    s1_b_q      <= bus.in_b;
                end
            end
            if (adv2) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_result_q <= result_d;
                    out_nv_q     <= nv_d;
                    out_tag_q    <= s1_tag_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_fp_compare_pipe.sv
// Self-checking bench: a 64-bit and a 32-bit unit driven by directed steps, scoreboard on retire.
module tb_fp_compare_pipe;
    import fp_pkg::*;

    typedef struct packed {
        logic [63:0] res;
        logic        nv;
        logic [4:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_compare_pipe_if #(.BUS_WIDTH(64), .TAG_WIDTH(5)) i64 ();
    fp_compare_pipe_if #(.BUS_WIDTH(32), .TAG_WIDTH(5)) i32 ();

    fp_compare_pipe #(.BUS_WIDTH(64), .TAG_WIDTH(5)) u_dut64 (.clk(clk), .rst(rst), .bus(i64));
    fp_compare_pipe #(.BUS_WIDTH(32), .TAG_WIDTH(5)) u_dut32 (.clk(clk), .rst(rst), .bus(i32));

    exp_t q64[$];
    exp_t q32[$];
    int total = 0;
    int bad = 0;
    int retired64 = 0;
    logic [4:0] tag_ctr = '0;
    bit rnd_done = 1'b0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", name, obs, exp);
        end
    endtask

    // Reference model: maps each value to an unsigned key whose order is the FP total order.
    function automatic logic [64:0] model(input bit w32, input logic [2:0] op,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [63:0] sgn, mask, canon, ka, kb, res;
        logic na, nb, sna, snb, za, zb, nv;
        if (w32) begin
            sgn = 64'h8000_0000; mask = 64'hFFFF_FFFF; canon = 64'h7FC0_0000;
            na = (a[30:23] == 8'hFF) && (a[22:0] != 0); sna = na && !a[22];
            nb = (b[30:23] == 8'hFF) && (b[22:0] != 0); snb = nb && !b[22];
        end else begin
            sgn = 64'h8000_0000_0000_0000; mask = '1; canon = 64'h7FF8_0000_0000_0000;
            na = (a[62:52] == 11'h7FF) && (a[51:0] != 0); sna = na && !a[51];
            nb = (b[62:52] == 11'h7FF) && (b[51:0] != 0); snb = nb && !b[51];
        end
        za = ((a & mask & ~sgn) == 0);
        zb = ((b & mask & ~sgn) == 0);
        ka = ((a & sgn) != 0) ? (~a & mask) : (a | sgn);
        kb = ((b & sgn) != 0) ? (~b & mask) : (b | sgn);
        res = '0;
        nv = 1'b0;
        case (op)
            3'd0: begin
                nv = sna || snb;
                res = (na && nb) ? canon : na ? b : nb ? a : (kb < ka) ? b : a;
            end
            3'd1: begin
                nv = sna || snb;
                res = (na && nb) ? canon : na ? b : nb ? a : (ka < kb) ? b : a;
            end
            3'd2: begin
                nv = sna || snb;
                res[0] = !(na || nb) && ((ka == kb) || (za && zb));
            end
            3'd3: begin
                nv = na || nb;
                res[0] = !(na || nb) && (ka < kb) && !(za && zb);
            end
            3'd4: begin
                nv = na || nb;
                res[0] = !(na || nb) && ((ka <= kb) || (za && zb));
            end
            default: ;
        endcase
        return {nv, res};
    endfunction

    function automatic logic [63:0] pick(input bit w32);
        int unsigned k;
        k = $urandom_range(0, 12);
        case (k)
            0:  return 64'h0;
            1:  return w32 ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
            2:  return w32 ? 64'h3F80_0000 : 64'h3FF0_0000_0000_0000;
            3:  return w32 ? 64'hBF80_0000 : 64'hBFF0_0000_0000_0000;
            4:  return w32 ? 64'h7F80_0000 : 64'h7FF0_0000_0000_0000;
            5:  return w32 ? 64'hFF80_0000 : 64'hFFF0_0000_0000_0000;
            6:  return w32 ? 64'h7FC0_0000 : 64'h7FF8_0000_0000_0000;
            7:  return w32 ? 64'h7F80_0001 : 64'h7FF0_0000_0000_0001;
            8:  return w32 ? 64'hFFC0_0005 : 64'hFFF8_0000_0000_0005;
            9:  return 64'h1;
            10: return w32 ? 64'h3F80_0001 : 64'h3FF0_0000_0000_0001;
            default: return w32 ? {32'h0, $urandom} : {$urandom, $urandom};
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input bit w32, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] er, input logic en);
        int waited = 0;
        bit ok = 1'b0;
        exp_t e;
        e = '{res: er, nv: en, tag: tag_ctr};
        if (w32) begin
            i32.in_valid = 1'b1; i32.in_op = op; i32.in_a = a[31:0]; i32.in_b = b[31:0];
            i32.in_tag = tag_ctr;
        end else begin
            i64.in_valid = 1'b1; i64.in_op = op; i64.in_a = a; i64.in_b = b;
            i64.in_tag = tag_ctr;
        end
        while (!ok && waited < 50) begin
            @(negedge clk);
            ok = w32 ? (i32.in_ready === 1'b1) : (i64.in_ready === 1'b1);
            waited++;
        end
        check("accept", 64'(ok), 64'h1);
        @(posedge clk);
        if (ok) begin
            if (w32) q32.push_back(e);
            else q64.push_back(e);
        end
        #1;
        if (w32) i32.in_valid = 1'b0;
        else i64.in_valid = 1'b0;
        tag_ctr++;
    endtask

    task automatic sendm(input bit w32, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b);
        logic [64:0] m;
        m = model(w32, op, a, b);
        send(w32, op, a, b, m[63:0], m[64]);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q64.size() != 0 || q32.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(q64.size() + q32.size()), 64'h0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst !== 1'b1 && i64.out_valid === 1'b1 && i64.out_ready === 1'b1) begin
            exp_t e;
            retired64++;
            if (q64.size() == 0) begin
                check("spurious64", 64'(i64.out_valid), 64'h0);
            end else begin
                e = q64.pop_front();
                check("res64", i64.out_result, e.res);
                check("nv64", 64'(i64.out_nv), 64'(e.nv));
                check("tag64", 64'(i64.out_tag), 64'(e.tag));
            end
        end
        if (rst !== 1'b1 && i32.out_valid === 1'b1 && i32.out_ready === 1'b1) begin
            exp_t e;
            if (q32.size() == 0) begin
                check("spurious32", 64'(i32.out_valid), 64'h0);
            end else begin
                e = q32.pop_front();
                check("res32", 64'(i32.out_result), e.res);
                check("nv32", 64'(i32.out_nv), 64'(e.nv));
                check("tag32", 64'(i32.out_tag), 64'(e.tag));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [64:0] m1;
        logic [4:0]  tag1;
        int snap;
        rst = 1'b1;
        i64.in_valid = 1'b0; i64.in_op = '0; i64.in_a = '0; i64.in_b = '0; i64.in_tag = '0;
        i64.out_ready = 1'b1;
        i32.in_valid = 1'b0; i32.in_op = '0; i32.in_a = '0; i32.in_b = '0; i32.in_tag = '0;
        i32.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst out_valid", 64'(i64.out_valid), 64'h0);
        check("rst out_result", i64.out_result, 64'h0);
        check("rst out_nv", 64'(i64.out_nv), 64'h0);
        check("rst out_tag", 64'(i64.out_tag), 64'h0);
        check("rst in_ready", 64'(i64.in_ready), 64'h1);
        check("rst out_valid32", 64'(i32.out_valid), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Latency: accepted at N, visible at N+2
        send(0, FP_OP_FMIN, 64'hBFF0_0000_0000_0000, 64'h4000_0000_0000_0000,
             64'hBFF0_0000_0000_0000, 1'b0);
        @(negedge clk);
        check("lat N+1", 64'(i64.out_valid), 64'h0);
        @(negedge clk);
        check("lat N+2", 64'(i64.out_valid), 64'h1);
        @(posedge clk);
        #1;

        // Signed zeros
        send(1, FP_OP_FMAX, 64'h8000_0000, 64'h0, 64'h0, 1'b0);
        send(1, FP_OP_FMIN, 64'h8000_0000, 64'h0, 64'h8000_0000, 1'b0);
        // NaN handling
        send(1, FP_OP_FMIN, 64'h7F80_0001, 64'h3F80_0000, 64'h3F80_0000, 1'b1);
        send(1, FP_OP_FMIN, 64'h7FC0_0001, 64'h7FC0_0001, 64'h7FC0_0000, 1'b0);
        send(0, FP_OP_FMAX, 64'h7FF0_0000_0000_0001, 64'hFFF8_0000_0000_0000,
             64'h7FF8_0000_0000_0000, 1'b1);
        // Compares
        send(0, FP_OP_FLT, 64'h7FF8_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'h0, 1'b1);
        send(0, FP_OP_FEQ, 64'h7FF8_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'h0, 1'b0);
        send(0, FP_OP_FLE, 64'h0, 64'h8000_0000_0000_0000, 64'h1, 1'b0);
        send(0, FP_OP_FLT, 64'h0, 64'h8000_0000_0000_0000, 64'h0, 1'b0);
        send(0, 3'd6, 64'h7FF0_0000_0000_0001, 64'h1, 64'h0, 1'b0);
        wait_drain();

        // Back-pressure with 4 back-to-back ops
        i64.out_ready = 1'b0;
        tag1 = tag_ctr;
        m1 = model(0, FP_OP_FMAX, 64'hC000_0000_0000_0000, 64'hBFF0_0000_0000_0000);
        fork
            begin
                sendm(0, FP_OP_FMAX, 64'hC000_0000_0000_0000, 64'hBFF0_0000_0000_0000);
                sendm(0, FP_OP_FMIN, 64'h3FF0_0000_0000_0000, 64'hFFF0_0000_0000_0000);
                sendm(0, FP_OP_FLE, 64'hBFF0_0000_0000_0000, 64'hBFF0_0000_0000_0000);
                sendm(0, FP_OP_FEQ, 64'h7FF0_0000_0000_0001, 64'h0);
            end
            begin
                repeat (3) @(negedge clk);
                check("bp in_ready", 64'(i64.in_ready), 64'h0);
                check("bp out_valid", 64'(i64.out_valid), 64'h1);
                check("bp accepted", 64'(q64.size()), 64'h2);
                repeat (2) @(negedge clk);
                check("bp hold result", i64.out_result, m1[63:0]);
                check("bp hold tag", 64'(i64.out_tag), 64'(tag1));
                @(posedge clk);
                #1;
                i64.out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset with two ops in flight
        i64.out_ready = 1'b0;
        sendm(0, FP_OP_FMIN, 64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000);
        sendm(0, FP_OP_FMAX, 64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000);
        rst = 1'b1;
        q64.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("flush out_valid", 64'(i64.out_valid), 64'h0);
        check("flush out_result", i64.out_result, 64'h0);
        check("flush in_ready", 64'(i64.in_ready), 64'h1);
        i64.out_ready = 1'b1;
        snap = retired64;
        repeat (5) @(negedge clk);
        check("flush no stale", 64'(retired64 - snap), 64'h0);
        @(posedge clk);
        #1;

        // Mixed random ops with random consumer stalls
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    bit w;
                    w = $urandom_range(0, 1) != 0;
                    sendm(w, 3'($urandom_range(0, 7)), pick(w), pick(w));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    i64.out_ready = $urandom_range(0, 3) != 0;
                    i32.out_ready = $urandom_range(0, 3) != 0;
                end
            end
        join
        i64.out_ready = 1'b1;
        i32.out_ready = 1'b1;
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
